// File: rtl/nrd_pkg.sv
// Shared types and sizes for the 8-bit non-restoring divider control unit.
package nrd_pkg;

   localparam int NRD_WIDTH = 8;
   localparam int NRD_ITER  = 8;
   localparam int CNT_W     = $clog2(NRD_ITER);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      LOAD_A  = 4'd1,
      LOAD_Q  = 4'd2,
      LOAD_M  = 4'd3,
      SHIFT   = 4'd4,
      ADDSUB  = 4'd5,
      SETQ    = 4'd6,
      CORRECT = 4'd7,
      OUT_Q   = 4'd8,
      OUT_A   = 4'd9,
      DONE    = 4'd10
   } nrd_state_e;

endpackage

// File: rtl/nrd_step_counter.sv
// Iteration counter for the divider: counts completed SETQ steps, flags the last one.
module nrd_step_counter
   import nrd_pkg::*;
(
   input  logic             clk,
   input  logic             rst_b,
   input  logic             clear_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o,
   output logic             last_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (inc_i) begin
         // Natural wrap from NRD_ITER-1 back to 0 ends the division cleanly.
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign last_o  = (count_q == CNT_W'(NRD_ITER - 1));

endmodule

// File: rtl/nrd_control_unit.sv
// Control FSM for an 8-bit non-restoring divider datapath (A, Q, M registers).
// Optional divide-by-zero abort enabled by defining NRD_DIV0_CHECK_EN.
module nrd_control_unit
   import nrd_pkg::*;
(
   input  logic             clk,
   input  logic             rst_b,
   input  logic             start,
   input  logic             s,
   input  logic             m_zero,
   output logic             c0,
   output logic             c1,
   output logic             c2,
   output logic             c3,
   output logic             c4,
   output logic             c5,
   output logic             c6,
   output logic             c7,
   output logic             c8,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [3:0]       dbg_state_o,
   output logic [CNT_W-1:0] dbg_iter_o
);

   nrd_state_e state_q;
   nrd_state_e state_d;
   logic       sign_q;
   logic       sign_d;
   logic       div0_q;
   logic       div0_d;
   logic       cnt_clear;
   logic       cnt_inc;
   logic       cnt_last;

   nrd_step_counter u_step_counter (
      .clk     (clk),
      .rst_b   (rst_b),
      .clear_i (cnt_clear),
      .inc_i   (cnt_inc),
      .count_o (dbg_iter_o),
      .last_o  (cnt_last)
   );

   always_comb begin
      state_d   = state_q;
      sign_d    = sign_q;
      div0_d    = div0_q;
      cnt_clear = 1'b0;
      cnt_inc   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = LOAD_A;
               cnt_clear = 1'b1;
               div0_d    = 1'b0;
            end
         end
         LOAD_A: state_d = LOAD_Q;
         LOAD_Q: state_d = LOAD_M;
         LOAD_M: begin
`ifdef NRD_DIV0_CHECK_EN
            if (m_zero) begin
               state_d = DONE;
               div0_d  = 1'b1;
            end else begin
               state_d = SHIFT;
            end
`else
            state_d = SHIFT;
`endif
         end
         SHIFT: begin
            // Sign of A before the shift decides add vs subtract next cycle.
            sign_d  = s;
            state_d = ADDSUB;
         end
         ADDSUB: state_d = SETQ;
         SETQ: begin
            cnt_inc = 1'b1;
            state_d = cnt_last ? CORRECT : SHIFT;
         end
         CORRECT: state_d = OUT_Q;
         OUT_Q:   state_d = OUT_A;
         OUT_A:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= IDLE;
         sign_q  <= 1'b0;
         div0_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         div0_q  <= div0_d;
      end
   end

   // Controls are decoded from the registered state only; start never reaches them.
   always_comb begin
      c0 = 1'b0;
      c1 = 1'b0;
      c2 = 1'b0;
      c3 = 1'b0;
      c4 = 1'b0;
      c5 = 1'b0;
      c6 = 1'b0;
      c7 = 1'b0;
      c8 = 1'b0;
      case (state_q)
         LOAD_A:  c0 = 1'b1;
         LOAD_Q:  c1 = 1'b1;
         LOAD_M:  c2 = 1'b1;
         SHIFT:   c6 = 1'b1;
         ADDSUB: begin
            c3 = 1'b1;
            c4 = ~sign_q;
         end
         SETQ:    c5 = 1'b1;
         CORRECT: c3 = s;
         OUT_Q:   c7 = 1'b1;
         OUT_A:   c8 = 1'b1;
         default: ;
      endcase
   end

   assign busy        = (state_q != IDLE) && (state_q != DONE);
   assign done        = (state_q == DONE);
   assign dbg_state_o = state_q;

`ifdef NRD_DIV0_CHECK_EN
   assign div0 = div0_q;
`else
   logic unused_m_zero;
   logic unused_div0_q;
   assign unused_m_zero = m_zero;
   assign unused_div0_q = div0_q;
   assign div0          = 1'b0;
`endif

endmodule

// File: tb/tb_nrd_control_unit.sv
// Scoreboard bench for nrd_control_unit: per-cycle expected control vectors from a schedule model.
module tb_nrd_control_unit;
   import nrd_pkg::*;

`ifdef NRD_DIV0_CHECK_EN
   localparam bit DIV0_EN = 1'b1;
`else
   localparam bit DIV0_EN = 1'b0;
`endif

   logic             clk;
   logic             rst_b;
   logic             start;
   logic             s;
   logic             m_zero;
   logic             c0, c1, c2, c3, c4, c5, c6, c7, c8;
   logic             busy, done, div0;
   logic [3:0]       dbg_state;
   logic [CNT_W-1:0] dbg_iter;

   logic [11:0] exp_q[$];
   int          n_vec;
   int          n_err;

   // Reference model: position within a run, counted in cycles since start.
   bit   m_active;
   int   m_off;
   logic m_sgn;
   logic m_div0;

   nrd_control_unit dut (
      .clk         (clk),
      .rst_b       (rst_b),
      .start       (start),
      .s           (s),
      .m_zero      (m_zero),
      .c0          (c0),
      .c1          (c1),
      .c2          (c2),
      .c3          (c3),
      .c4          (c4),
      .c5          (c5),
      .c6          (c6),
      .c7          (c7),
      .c8          (c8),
      .busy        (busy),
      .done        (done),
      .div0        (div0),
      .dbg_state_o (dbg_state),
      .dbg_iter_o  (dbg_iter)
   );

   // clock / reset
   initial begin
      clk    = 1'b0;
      rst_b  = 1'b0;
      start  = 1'b0;
      s      = 1'b0;
      m_zero = 1'b0;
   end
   always #5 clk = ~clk;

   // Vector layout: {c8..c0, busy, done, div0}
   function automatic logic [11:0] model_out(input logic sv, input logic rb);
      logic [8:0] c;
      logic       b;
      logic       d;
      c = '0;
      b = 1'b0;
      d = 1'b0;
      if (!rb) return 12'h000;
      if (m_active) begin
         if (m_off >= 1 && m_off <= 3) begin
            c[m_off-1] = 1'b1;
         end else if (m_off >= 4 && m_off <= 27) begin
            case ((m_off - 4) % 3)
               0: c[6] = 1'b1;
               1: begin c[3] = 1'b1; c[4] = ~m_sgn; end
               default: c[5] = 1'b1;
            endcase
         end else if (m_off == 28) begin
            c[3] = sv;
         end else if (m_off == 29) begin
            c[7] = 1'b1;
         end else if (m_off == 30) begin
            c[8] = 1'b1;
         end else if (m_off == 31) begin
            d = 1'b1;
         end
         b = (m_off <= 30);
      end
      return {c, b, d, m_div0};
   endfunction

   task automatic model_advance(input logic st, input logic sv, input logic mz, input logic rb);
      if (!rb) begin
         m_active = 1'b0;
         m_off    = 0;
         m_sgn    = 1'b0;
         m_div0   = 1'b0;
      end else if (m_active) begin
         if (m_off >= 4 && m_off <= 27 && ((m_off - 4) % 3) == 0) m_sgn = sv;
         if (DIV0_EN && m_off == 3 && mz) begin
            m_off  = 31;
            m_div0 = 1'b1;
         end else begin
            m_off = m_off + 1;
         end
         if (m_off > 31) m_active = 1'b0;
      end else if (st) begin
         m_active = 1'b1;
         m_off    = 1;
         m_div0   = 1'b0;
      end
   endtask

   // driver: one clock cycle of inputs, expected response queued
   task automatic step(input logic st, input logic sv, input logic mz, input logic rb);
      @(posedge clk);
      #1;
      rst_b  = rb;
      start  = st;
      s      = sv;
      m_zero = mz;
      exp_q.push_back(model_out(sv, rb));
      model_advance(st, sv, mz, rb);
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [11:0] exp_v;
         logic [11:0] act_v;
         exp_v = exp_q.pop_front();
         act_v = {c8, c7, c6, c5, c4, c3, c2, c1, c0, busy, done, div0};
         n_vec++;
         if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL ctrl_vec t=%0t state=%0d got=%b expected=%b ({c8..c0,busy,done,div0})",
                     $time, dbg_state, act_v, exp_v);
         end
      end
   end

   initial begin
      n_vec    = 0;
      n_err    = 0;
      m_active = 1'b0;
      m_off    = 0;
      m_sgn    = 1'b0;
      m_div0   = 1'b0;

      // reset state
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
      idle_steps(3);

      // plain run, s=0 throughout
      step(1'b1, 1'b0, 1'b0, 1'b1);
      idle_steps(34);

      // sign: s high in SHIFT of iterations 3 and 8, and during CORRECT
      step(1'b1, 1'b0, 1'b0, 1'b1);
      for (int o = 1; o <= 33; o++)
         step(1'b0, (o == 10 || o == 25 || o == 28), 1'b0, 1'b1);

      // start pulses while busy are ignored
      step(1'b1, 1'b0, 1'b0, 1'b1);
      for (int o = 1; o <= 33; o++)
         step((o == 5 || o == 20), 1'b0, 1'b0, 1'b1);

      // reset mid-run, recovery with a fresh start
      step(1'b1, 1'b0, 1'b0, 1'b1);
      for (int o = 1; o <= 14; o++)
         step((o == 14), 1'b0, 1'b0, !(o == 10 || o == 11));
      idle_steps(34);

      // divisor zero reported at LOAD_M, then a normal run
      step(1'b1, 1'b0, 1'b0, 1'b1);
      for (int o = 1; o <= 8; o++)
         step(1'b0, 1'b0, (o == 3), 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      idle_steps(34);

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         step(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) != 0));
      end
      idle_steps(2);

      @(posedge clk);
      @(negedge clk);
      #1;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL queue_drain got=%0d pending expected=0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/nrd_control_unit.md
NRD_CONTROL_UNIT -- requirements
Module: nrd_control_unit

Interface
REQ-001 The block SHALL have the port `clk  input  1`: rising-edge clock.
REQ-002 The block SHALL have the port `rst_b  input  1`: reset, asynchronous, active-low.
REQ-003 The block SHALL have the port `start  input  1`: request to begin one 8-bit non-restoring division; sampled only in IDLE.
REQ-004 The block SHALL have the port `s  input  1`: sign bit A[8] from the A register, registered value.
REQ-005 The block SHALL have the port `m_zero  input  1`: high when the divisor on inbus is zero; meaningful only during LOAD_M.
REQ-006 The block SHALL have the ports `c0..c8  output  1 each`: datapath controls, one-hot per cycle except c4:
- c0 load A
- c1 load Q
- c2 load M
- c3 write adder result to A
- c4 adder op (1=A-M, 0=A+M)
- c5 set Q[0]=~s
- c6 shift A.Q left
- c7 drive Q on outbus
- c8 drive A on outbus
REQ-007 The block SHALL have the ports `busy  output  1` and `done  output  1`, plus `div0  output  1` (divide-by-zero flag).

Function
REQ-008 The FSM states SHALL be IDLE, LOAD_A, LOAD_Q, LOAD_M, SHIFT, ADDSUB, SETQ, CORRECT, OUT_Q, OUT_A, DONE.
REQ-009 IDLE SHALL go to LOAD_A on start=1; start is ignored in every other state.
REQ-010 LOAD_A→LOAD_Q→LOAD_M→SHIFT SHALL advance unconditionally, asserting c0, c1 and c2 respectively.
REQ-011 SHIFT SHALL assert c6, latch s into sign_q, and go to ADDSUB.
REQ-012 ADDSUB SHALL assert c3 with c4=~sign_q (subtract when A was non-negative), then go to SETQ.
REQ-013 SETQ SHALL assert c5 and increment a 3-bit iteration counter; it SHALL go to SHIFT if the counter was <7 and to CORRECT when it was 7 (wrap to 0).
REQ-014 CORRECT SHALL assert c3 with c4=0 only if s=1, otherwise assert no control; it always lasts exactly 1 cycle and then goes to OUT_Q.
REQ-015 OUT_Q SHALL assert c7, OUT_A SHALL assert c8, then go to DONE; DONE SHALL pulse done for 1 cycle and return to IDLE.
REQ-016 Latency SHALL be fixed: with start high in IDLE at cycle 0, c0 occurs at cycle 1, iterations at cycles 4–27, CORRECT at 28, c7 at 29, c8 at 30, done at 31.
REQ-017 busy SHALL be high in every state except IDLE and DONE.
REQ-018 All outputs SHALL be driven by registered or state-decoded logic with no combinational path from start to any c-signal.
REQ-019 c4 SHALL be 0 whenever c3 is 0.

Reset
REQ-020 When rst_b=0 at any time, including mid-division, the state SHALL become IDLE, the counter 0, sign_q 0, and c0..c8, busy, done and div0 all 0, with no further controls issued until a new start.

Configuration
REQ-021 When NRD_DIV0_CHECK_EN is defined and m_zero=1 in LOAD_M, the FSM SHALL go directly to DONE, set div0=1 with the done pulse, and hold div0 until the next accepted start.
REQ-022 When NRD_DIV0_CHECK_EN is undefined, m_zero SHALL be ignored and div0 tied to 0.

Structure
REQ-023 Package nrd_pkg SHALL hold the state enum typedef, NRD_WIDTH=8 and NRD_ITER=8.
REQ-024 The iteration counter SHALL be a sub-module nrd_step_counter with clear, increment and last outputs.

Verification
REQ-025 Reset check: assert rst_b=0 mid-run → all outputs are 0 in the same cycle, and idle persists with start=0.
REQ-026 Timing check: start at cycle 0 with s=0 throughout → c0@1, c1@2, c2@3; c6/c3/c5 triplets at 4..27 with c4=1; c3 absent @28; c7@29, c8@30, done@31; busy high from 1 to 30.
REQ-027 Sign check: s=1 during SHIFT of iterations 3 and 8 → c4=0 in those ADDSUB cycles; s=1 at 28 → c3=1 and c4=0.
REQ-028 Busy check: start pulsed at cycles 5 and 20 → ignored, and the sequence is identical to the REQ-026 sequence.
REQ-029 Reset-recovery check: rst_b low at cycle 10, released at 12, start at 14 → a full sequence with c0@15 and the counter restarting from 0.
REQ-030 Macro check: with NRD_DIV0_CHECK_EN defined and m_zero=1 at cycle 3 → no c6, done@4 with div0=1, and div0 cleared at the next start; with the macro undefined → the normal 31-cycle run and div0=0.
